// File: rtl/nfi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nfi_sequencer
// Purpose  : Runs one next-field iteration of the Game of Life field.
//            A go pulse from the rate controller starts a row-major walk over
//            every cell. Each cell is handed to the cell-update datapath with
//            a req/ack handshake. After the last cell the block waits for
//            vertical blanking, then pulses a front/back buffer swap.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   FIELD_W    field width in cells (>= 2)
//   FIELD_H    field height in cells (>= 2)
//   ITER_BITS  width of the completed-iteration counter
//   X_BITS / Y_BITS  derived column / row index widths
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   i_go        one-cycle start pulse, honoured only when idle
//   i_vblank    display vertical blanking level
//   i_abort     (only with NFI_SEQ_ABORT_EN) abandon the running iteration
//   o_ready     high only when idle; drives the rate controller's allow input
//   o_cell_req  cell-update request valid
//   o_cell_x    column of the requested cell
//   o_cell_y    row of the requested cell
//   i_cell_ack  datapath consumed the current cell
//   o_swap      one-cycle front/back buffer swap pulse
//   o_done      one-cycle completion pulse, coincident with o_swap
//   o_iter_cnt  number of completed iterations (wraps)
// Build option
//   NFI_SEQ_ABORT_EN  adds the i_abort input
// ============================================================================
module nfi_sequencer #(
    parameter int FIELD_W   = 64,
    parameter int FIELD_H   = 48,
    parameter int ITER_BITS = 16,
    localparam int X_BITS   = $clog2(FIELD_W),
    localparam int Y_BITS   = $clog2(FIELD_H)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_go,
    input  logic                 i_vblank,
`ifdef NFI_SEQ_ABORT_EN
    input  logic                 i_abort,
`endif
    output logic                 o_ready,
    output logic                 o_cell_req,
    output logic [X_BITS-1:0]    o_cell_x,
    output logic [Y_BITS-1:0]    o_cell_y,
    input  logic                 i_cell_ack,
    output logic                 o_swap,
    output logic                 o_done,
    output logic [ITER_BITS-1:0] o_iter_cnt
);

    localparam logic [X_BITS-1:0]    c_X_LAST   = X_BITS'(FIELD_W - 1);
    localparam logic [Y_BITS-1:0]    c_Y_LAST   = Y_BITS'(FIELD_H - 1);
    localparam logic [X_BITS-1:0]    c_X_ONE    = X_BITS'(1);
    localparam logic [Y_BITS-1:0]    c_Y_ONE    = Y_BITS'(1);
    localparam logic [ITER_BITS-1:0] c_ITER_ONE = ITER_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_WAIT_VB = 2'd2,
        ST_SWAP    = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_ready;
    logic                   r_cell_req;
    logic [X_BITS-1:0]      r_x;
    logic [Y_BITS-1:0]      r_y;
    logic                   r_swap;
    logic                   r_done;
    logic [ITER_BITS-1:0]   r_iter_cnt;
    logic                   w_abort;

`ifdef NFI_SEQ_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
            r_cell_req <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_swap     <= 1'b0;
            r_done     <= 1'b0;
            r_iter_cnt <= '0;
        end else begin
            // swap/done are single-cycle pulses; only the WAIT_VB exit raises them
            r_swap <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_go) begin
                        r_state    <= ST_SCAN;
                        r_ready    <= 1'b0;
                        r_cell_req <= 1'b1;
                        r_x        <= '0;
                        r_y        <= '0;
                    end
                end
                ST_SCAN: begin
                    // req is always high here, so ack alone marks a handshake.
                    // Abort takes priority over a simultaneous ack.
                    if (w_abort) begin
                        r_state    <= ST_IDLE;
                        r_ready    <= 1'b1;
                        r_cell_req <= 1'b0;
                        r_x        <= '0;
                        r_y        <= '0;
                    end else if (i_cell_ack) begin
                        if (r_x == c_X_LAST) begin
                            r_x <= '0;
                            if (r_y == c_Y_LAST) begin
                                r_y        <= '0;
                                r_cell_req <= 1'b0;
                                r_state    <= ST_WAIT_VB;
                            end else begin
                                r_y <= r_y + c_Y_ONE;
                            end
                        end else begin
                            r_x <= r_x + c_X_ONE;
                        end
                    end
                end
                ST_WAIT_VB: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else if (i_vblank) begin
                        r_state <= ST_SWAP;
                        r_swap  <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                ST_SWAP: begin
                    // go arriving during this cycle is dropped: ready is still low
                    r_state    <= ST_IDLE;
                    r_ready    <= 1'b1;
                    r_iter_cnt <= r_iter_cnt + c_ITER_ONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready    = r_ready;
    assign o_cell_req = r_cell_req;
    assign o_cell_x   = r_x;
    assign o_cell_y   = r_y;
    assign o_swap     = r_swap;
    assign o_done     = r_done;
    assign o_iter_cnt = r_iter_cnt;

endmodule

`default_nettype wire

// File: tb/tb_nfi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nfi_sequencer
// Purpose  : Self-checking bench for nfi_sequencer on a 4x3 field. Expected
//            cell coordinates are queued when an iteration is started and
//            popped by a monitor on every req/ack handshake.
//            Define NFI_SEQ_ABORT_EN to include the abort scenario.
// Revision : 1.0  initial release
// ============================================================================
module tb_nfi_sequencer;

    localparam int FW = 4;
    localparam int FH = 3;
    localparam int IB = 16;
    localparam int XB = $clog2(FW);
    localparam int YB = $clog2(FH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_go = 1'b0;
    logic          i_vblank = 1'b0;
    logic          i_cell_ack = 1'b0;
    logic          o_ready;
    logic          o_cell_req;
    logic [XB-1:0] o_cell_x;
    logic [YB-1:0] o_cell_y;
    logic          o_swap;
    logic          o_done;
    logic [IB-1:0] o_iter_cnt;
    logic          tb_abort;
`ifdef NFI_SEQ_ABORT_EN
    logic          i_abort = 1'b0;
    assign tb_abort = i_abort;
`else
    assign tb_abort = 1'b0;
`endif

    nfi_sequencer #(
        .FIELD_W   (FW),
        .FIELD_H   (FH),
        .ITER_BITS (IB)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_go       (i_go),
        .i_vblank   (i_vblank),
`ifdef NFI_SEQ_ABORT_EN
        .i_abort    (i_abort),
`endif
        .o_ready    (o_ready),
        .o_cell_req (o_cell_req),
        .o_cell_x   (o_cell_x),
        .o_cell_y   (o_cell_y),
        .i_cell_ack (i_cell_ack),
        .o_swap     (o_swap),
        .o_done     (o_done),
        .o_iter_cnt (o_iter_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int acks   = 0;
    int swaps  = 0;
    logic [XB+YB-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Handshake monitor: sampled mid-cycle, before the edge that commits it.
    always @(negedge clk) begin
        logic [XB+YB-1:0] e;
        if (!rst && o_cell_req && i_cell_ack && !tb_abort) begin
            acks++;
            if (exp_q.size() == 0) begin
                chk("cell_unexpected", {o_cell_x, o_cell_y}, 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("cell_xy", {o_cell_x, o_cell_y}, e);
            end
        end
        if (!rst && o_swap) begin
            swaps++;
            chk("done_with_swap", o_done, 1);
        end
        if (!rst && o_done && !o_swap) chk("done_without_swap", 0, 1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue the full row-major cell order, then pulse go.
    task automatic start_iter();
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++)
                exp_q.push_back({XB'(x), YB'(y)});
        i_go = 1'b1;
        cyc(1);
        i_go = 1'b0;
    endtask

    task automatic wait_swap(input string tag, input int budget);
        int n;
        n = 0;
        while (!o_swap && n < budget) begin
            cyc(1);
            n++;
        end
        if (!o_swap) chk(tag, 0, 1);
    endtask

    task automatic wait_cell(input string tag, input int x, input int y);
        int n;
        n = 0;
        while (!(o_cell_req && o_cell_x == XB'(x) && o_cell_y == YB'(y)) && n < 50) begin
            cyc(1);
            n++;
        end
        if (n >= 50) chk(tag, 0, 1);
    endtask

    initial begin
        int req_cycles, last_req, swap_at, s0, a0, unstable, got_swap, prev_hold;
        logic [XB+YB-1:0] prev_xy;

        // ---- Reset values
        cyc(2);
        chk("rst_ready", o_ready, 1);
        chk("rst_req", o_cell_req, 0);
        chk("rst_xy", {o_cell_x, o_cell_y}, 0);
        chk("rst_swap", o_swap, 0);
        chk("rst_done", o_done, 0);
        chk("rst_iter", o_iter_cnt, 0);
        rst = 1'b0;
        cyc(1);

        // ---- 1: ack and vblank tied high
        i_cell_ack = 1'b1;
        i_vblank   = 1'b1;
        s0 = swaps; a0 = acks;
        start_iter();
        req_cycles = 0; last_req = -1; swap_at = -1;
        for (int i = 0; i < 30; i++) begin
            if (i == 0) begin
                chk("t1_first_req", o_cell_req, 1);
                chk("t1_ready_low", o_ready, 0);
            end
            if (o_cell_req) begin
                req_cycles++;
                last_req = i;
            end
            if (o_swap && swap_at < 0) swap_at = i;
            cyc(1);
        end
        chk("t1_req_cycles", req_cycles, 12);
        chk("t1_swap_after_req_fall", swap_at, last_req + 2);
        chk("t1_swap_at", swap_at, 13);
        chk("t1_swap_count", swaps - s0, 1);
        chk("t1_acks", acks - a0, 12);
        chk("t1_iter", o_iter_cnt, 1);
        chk("t1_ready", o_ready, 1);
        chk("t1_queue_empty", exp_q.size(), 0);

        // ---- 2: ack only every 3rd cycle
        i_cell_ack = 1'b0;
        s0 = swaps; a0 = acks;
        start_iter();
        unstable = 0; got_swap = 0; prev_hold = 0; prev_xy = '0;
        for (int i = 0; i < 200 && got_swap == 0; i++) begin
            if (prev_hold != 0 && {o_cell_x, o_cell_y} !== prev_xy) unstable++;
            i_cell_ack = (i % 3 == 2);
            prev_hold  = (o_cell_req && !i_cell_ack) ? 1 : 0;
            prev_xy    = {o_cell_x, o_cell_y};
            if (o_swap) got_swap = 1;
            cyc(1);
        end
        i_cell_ack = 1'b0;
        cyc(2);
        chk("t2_swap_seen", got_swap, 1);
        chk("t2_xy_stable", unstable, 0);
        chk("t2_acks", acks - a0, 12);
        chk("t2_swap_count", swaps - s0, 1);
        chk("t2_iter", o_iter_cnt, 2);
        chk("t2_queue_empty", exp_q.size(), 0);

        // ---- 3: vblank low for 20 cycles after the last ack
        i_cell_ack = 1'b1;
        i_vblank   = 1'b0;
        s0 = swaps;
        start_iter();
        begin
            int n;
            n = 0;
            while (o_cell_req && n < 40) begin
                cyc(1);
                n++;
            end
            if (o_cell_req) chk("t3_req_fall_timeout", 0, 1);
        end
        for (int i = 0; i < 20; i++) begin
            if (o_swap || o_cell_req || o_ready) chk("t3_wait_vb_hold", {o_swap, o_cell_req, o_ready}, 0);
            cyc(1);
        end
        chk("t3_no_swap_yet", swaps - s0, 0);
        i_vblank = 1'b1;
        cyc(1);
        chk("t3_swap_after_vb", o_swap, 1);
        cyc(1);
        chk("t3_swap_single", o_swap, 0);
        chk("t3_iter", o_iter_cnt, 3);
        chk("t3_ready", o_ready, 1);

        // ---- 4: go pulsed mid-SCAN and during SWAP
        s0 = swaps;
        start_iter();
        cyc(5);
        i_go = 1'b1;
        cyc(1);
        i_go = 1'b0;
        wait_swap("t4_swap_timeout", 40);
        i_go = 1'b1;
        cyc(1);
        i_go = 1'b0;
        chk("t4_ready_after_swap", o_ready, 1);
        chk("t4_no_restart", o_cell_req, 0);
        cyc(20);
        chk("t4_req_idle", o_cell_req, 0);
        chk("t4_swap_count", swaps - s0, 1);
        chk("t4_iter", o_iter_cnt, 4);
        chk("t4_queue_empty", exp_q.size(), 0);

`ifdef NFI_SEQ_ABORT_EN
        // ---- 6: abort at cell (1,1) with ack high
        s0 = swaps;
        start_iter();
        wait_cell("t6_cell_timeout", 1, 1);
        i_abort = 1'b1;
        cyc(1);
        i_abort = 1'b0;
        chk("t6_ready", o_ready, 1);
        chk("t6_req", o_cell_req, 0);
        chk("t6_xy", {o_cell_x, o_cell_y}, 0);
        chk("t6_iter", o_iter_cnt, 4);
        exp_q.delete();
        cyc(10);
        chk("t6_no_swap", swaps - s0, 0);
        start_iter();
        chk("t6_restart_req", o_cell_req, 1);
        chk("t6_restart_xy", {o_cell_x, o_cell_y}, 0);
        wait_swap("t6_swap_timeout", 40);
        cyc(1);
        chk("t6_iter_after", o_iter_cnt, 5);
        chk("t6_queue_empty", exp_q.size(), 0);
`endif

        // ---- 5: reset at cell (2,1)
        s0 = swaps;
        start_iter();
        wait_cell("t5_cell_timeout", 2, 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        exp_q.delete();
        chk("t5_req", o_cell_req, 0);
        chk("t5_xy", {o_cell_x, o_cell_y}, 0);
        chk("t5_iter", o_iter_cnt, 0);
        chk("t5_ready", o_ready, 1);
        chk("t5_swap", o_swap, 0);
        cyc(20);
        chk("t5_no_swap", swaps - s0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
